// File: rtl/multi_pulse_generator_pkg.sv
// Shared types and default constants for the multi-channel pulse generator.
package pulse_gen_pkg;

  // Per-channel FSM state. IDLE must stay at encoding 0 so reset and
  // "not busy" coincide.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } pgen_state_t;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_REP_W = 16;

endpackage

// File: rtl/multi_pulse_generator_if.sv
// Signal bundle for driving and observing a multi_pulse_generator.
//
// Handshake: there is no valid/ready pair. start is a level per channel and
// only its rising edge (seen while the channel is idle and stop is low)
// launches a run; the run's configuration is sampled on that same clock edge.
// stop is a level abort honoured on any clock edge while the channel is busy.
// done is a one-cycle strobe the consumer must sample every cycle.
interface pgen_if
  import pulse_gen_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
);
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic [N_CH*CNT_W-1:0] delay_cycles;
  logic [N_CH*CNT_W-1:0] gap_cycles;
  logic [N_CH*CNT_W-1:0] width_cycles;
  logic [N_CH*REP_W-1:0] repetition;
  logic [N_CH-1:0]       pulse_out;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       done;

  modport master (
    output start, stop, delay_cycles, gap_cycles, width_cycles, repetition,
    input  pulse_out, busy, done
  );

  modport slave (
    input  start, stop, delay_cycles, gap_cycles, width_cycles, repetition,
    output pulse_out, busy, done
  );
endinterface

// File: rtl/multi_pulse_generator_channel.sv
// One independent pulse channel: delay, then a train of pulses separated by
// gaps, finite or endless, abortable by stop.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] gap_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [REP_W-1:0] rep_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output pgen_state_t      state_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  pgen_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REP_W-1:0] rem_q;
  logic [REP_W-1:0] rep_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] width_q;
  logic             start_q;
  logic             arm_q;
  logic             done_q;
  logic             start_edge;

  // Phase length minus one, with a zero request treated as one cycle.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction

  // arm_q blocks an edge that only appears because start was already high
  // when reset released; start must be seen low once before it can launch.
  assign start_edge = start_i & ~start_q & arm_q;

  // Channel FSM. The delay setting is consumed straight into the counter at
  // launch, so only gap, width and repetition need shadow copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      width_q <= '0;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      start_q <= start_i;
      arm_q   <= arm_q | ~start_i;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_edge && !stop_i) begin
            gap_q   <= gap_i;
            width_q <= width_i;
            rep_q   <= rep_i;
            rem_q   <= rep_i;
            cnt_q   <= load_val(delay_i);
            state_q <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (stop_i) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            cnt_q   <= load_val(width_q);
            state_q <= ST_PULSE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_PULSE: begin
          if (stop_i) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            if (rep_q != '0 && rem_q == REP_ONE) begin
              // Last pulse of a finite train: strobe done in the first IDLE cycle.
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              if (rep_q != '0) begin
                rem_q <= rem_q - REP_ONE;
              end
              cnt_q   <= load_val(gap_q);
              state_q <= ST_GAP;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (stop_i) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            cnt_q   <= load_val(width_q);
            state_q <= ST_PULSE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pulse_o = (state_q == ST_PULSE);
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: rtl/multi_pulse_generator.sv
// Array of N_CH independent pulse channels sharing one clock and reset.
module multi_pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH*CNT_W-1:0] delay_cycles,
  input  logic [N_CH*CNT_W-1:0] gap_cycles,
  input  logic [N_CH*CNT_W-1:0] width_cycles,
  input  logic [N_CH*REP_W-1:0] repetition,
  output logic [N_CH-1:0]       pulse_out,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic [2*N_CH-1:0]     dbg_state
);

  // One channel per slice of the packed configuration buses.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pgen_state_t ch_state;

    pulse_channel #(
      .CNT_W (CNT_W),
      .REP_W (REP_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (start[i]),
      .stop_i  (stop[i]),
      .delay_i (delay_cycles[i*CNT_W +: CNT_W]),
      .gap_i   (gap_cycles[i*CNT_W +: CNT_W]),
      .width_i (width_cycles[i*CNT_W +: CNT_W]),
      .rep_i   (repetition[i*REP_W +: REP_W]),
      .pulse_o (pulse_out[i]),
      .busy_o  (busy[i]),
      .done_o  (done[i]),
      .state_o (ch_state)
    );

    assign dbg_state[2*i +: 2] = ch_state;
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Self-checking bench for multi_pulse_generator.
module tb_multi_pulse_generator;

  localparam int NC = 4;
  localparam int CW = 32;
  localparam int RW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2*NC-1:0] dbg_state;

  always #5 clk = ~clk;

  pgen_if #(.N_CH(NC), .CNT_W(CW), .REP_W(RW)) bus ();

  multi_pulse_generator #(.N_CH(NC), .CNT_W(CW), .REP_W(RW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (bus.start),
    .stop         (bus.stop),
    .delay_cycles (bus.delay_cycles),
    .gap_cycles   (bus.gap_cycles),
    .width_cycles (bus.width_cycles),
    .repetition   (bus.repetition),
    .pulse_out    (bus.pulse_out),
    .busy         (bus.busy),
    .done         (bus.done),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  // Reference model: a run is just its launch edge plus the effective
  // delay/width/gap/count; every output follows from arithmetic on the
  // number of edges since launch.
  bit act[NC];
  int t0[NC], md[NC], mw[NC], mg[NC], mn[NC];
  bit prv[NC], armed[NC];
  logic [NC-1:0] exp_pulse, exp_busy, exp_done;
  logic [7:0] exp_q[$];

  function automatic int at_least_one(int v);
    return (v == 0) ? 1 : v;
  endfunction

  // {busy, pulse, done} during the cycle after edge e
  function automatic logic [2:0] stat(int ch, int e);
    int rel, p, per, pend;
    if (!act[ch]) return 3'b000;
    rel = e - t0[ch];
    if (rel < 0) return 3'b000;
    if (rel < md[ch]) return 3'b100;
    p = rel - md[ch];
    per = mw[ch] + mg[ch];
    if (mn[ch] > 0) begin
      pend = mn[ch] * mw[ch] + (mn[ch] - 1) * mg[ch];
      if (p == pend) return 3'b001;
      if (p > pend) return 3'b000;
    end
    if ((p % per) < mw[ch]) return 3'b110;
    return 3'b100;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NC; ch++) begin
      act[ch] = 1'b0;
      prv[ch] = 1'b0;
      armed[ch] = 1'b0;
    end
    exp_pulse = '0;
    exp_busy = '0;
    exp_done = '0;
  endtask

  task automatic refresh_exp();
    logic [2:0] s;
    for (int ch = 0; ch < NC; ch++) begin
      s = stat(ch, edge_n);
      exp_busy[ch] = s[2];
      exp_pulse[ch] = s[1];
      exp_done[ch] = s[0];
    end
  endtask

  // Advance one clock: model consumes the inputs seen at the rising edge,
  // returns at the falling edge where outputs are compared.
  task automatic step();
    logic [2:0] s;
    bit bp;
    @(posedge clk);
    if (reset_n) begin
      edge_n++;
      for (int ch = 0; ch < NC; ch++) begin
        s = stat(ch, edge_n - 1);
        bp = act[ch] && s[2];
        if (bp && bus.stop[ch]) begin
          act[ch] = 1'b0;
        end else if (!bp && !bus.stop[ch] && bus.start[ch] && !prv[ch] && armed[ch]) begin
          act[ch] = 1'b1;
          t0[ch] = edge_n;
          md[ch] = at_least_one(int'(bus.delay_cycles[ch*CW +: CW]));
          mw[ch] = at_least_one(int'(bus.width_cycles[ch*CW +: CW]));
          mg[ch] = at_least_one(int'(bus.gap_cycles[ch*CW +: CW]));
          mn[ch] = int'(bus.repetition[ch*RW +: RW]);
        end
        prv[ch] = bus.start[ch];
        if (!bus.start[ch]) armed[ch] = 1'b1;
      end
    end
    refresh_exp();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int ch, input int d, input int w, input int g, input int r);
    bus.delay_cycles[ch*CW +: CW] = CW'(d);
    bus.width_cycles[ch*CW +: CW] = CW'(w);
    bus.gap_cycles[ch*CW +: CW] = CW'(g);
    bus.repetition[ch*RW +: RW] = RW'(r);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = '0;
    bus.stop = '0;
    for (int ch = 0; ch < NC; ch++) set_cfg(ch, 5, 5, 5, 5);
    model_reset();
    repeat (3) step();
    checks++;
    if (bus.pulse_out !== '0) begin failures++; $display("FAIL reset_pulse got=%b exp=0", bus.pulse_out); end
    checks++;
    if (bus.busy !== '0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.done !== '0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    reset_n = 1'b1;
    repeat (2) step();
    checks++;
    if (bus.busy !== '0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic();
    logic ep, ed, prevp;
    logic [7:0] x;
    set_cfg(0, 3, 2, 4, 3);
    exp_q.push_back(8'd4);
    exp_q.push_back(8'd10);
    exp_q.push_back(8'd16);
    prevp = 1'b0;
    bus.start[0] = 1'b1;
    step();
    for (int c = 1; c <= 22; c++) begin
      bus.start[0] = 1'b0;
      checks++;
      if ({bus.busy, bus.pulse_out, bus.done} !== {exp_busy, exp_pulse, exp_done}) begin
        failures++;
        $display("FAIL basic_model c=%0d got b=%b p=%b d=%b exp b=%b p=%b d=%b",
                 c, bus.busy, bus.pulse_out, bus.done, exp_busy, exp_pulse, exp_done);
      end
      ep = (c == 4 || c == 5 || c == 10 || c == 11 || c == 16 || c == 17);
      ed = (c == 18);
      checks++;
      if (bus.pulse_out[0] !== ep || bus.done[0] !== ed) begin
        failures++;
        $display("FAIL basic_fixed c=%0d got p=%b d=%b exp p=%b d=%b", c, bus.pulse_out[0], bus.done[0], ep, ed);
      end
      if (bus.pulse_out[0] === 1'b1 && prevp === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL basic_rise c=%0d got=extra_rise exp=none", c);
        end else begin
          x = exp_q.pop_front();
          if (x != 8'(c)) begin
            failures++;
            $display("FAIL basic_rise got=%0d exp=%0d", c, x);
          end
        end
      end
      prevp = bus.pulse_out[0];
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_missing got=%0d_left exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_min();
    logic ep, ed;
    set_cfg(1, 0, 0, 0, 2);
    bus.start[1] = 1'b1;
    step();
    for (int c = 1; c <= 7; c++) begin
      bus.start[1] = 1'b0;
      checks++;
      if ({bus.busy, bus.pulse_out, bus.done} !== {exp_busy, exp_pulse, exp_done}) begin
        failures++;
        $display("FAIL min_model c=%0d got b=%b p=%b d=%b exp b=%b p=%b d=%b",
                 c, bus.busy, bus.pulse_out, bus.done, exp_busy, exp_pulse, exp_done);
      end
      ep = (c == 2 || c == 4);
      ed = (c == 5);
      checks++;
      if (bus.pulse_out[1] !== ep || bus.done[1] !== ed) begin
        failures++;
        $display("FAIL min_fixed c=%0d got p=%b d=%b exp p=%b d=%b", c, bus.pulse_out[1], bus.done[1], ep, ed);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(1, 0, 0, 0, 1);
    bus.start[1] = 1'b1;
    step();
    bus.start[1] = 1'b0;
    step();
    step();
    checks++;
    if (bus.done[1] !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", bus.done[1]); end
    bus.start[1] = 1'b1;
    step();
    checks++;
    if (bus.busy[1] !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b exp=1", bus.busy[1]); end
    for (int c = 1; c <= 5; c++) begin
      bus.start[1] = 1'b0;
      checks++;
      if ({bus.busy, bus.pulse_out, bus.done} !== {exp_busy, exp_pulse, exp_done}) begin
        failures++;
        $display("FAIL b2b_model c=%0d got b=%b p=%b d=%b exp b=%b p=%b d=%b",
                 c, bus.busy, bus.pulse_out, bus.done, exp_busy, exp_pulse, exp_done);
      end
      step();
    end
  endtask

  task automatic test_inf_stop();
    int rises;
    bit found;
    logic prevp;
    rises = 0;
    found = 1'b0;
    prevp = 1'b0;
    set_cfg(2, 1, 2, 1, 0);
    bus.start[2] = 1'b1;
    step();
    for (int c = 1; c <= 60 && !found; c++) begin
      bus.start[2] = 1'b0;
      checks++;
      if ({bus.busy, bus.pulse_out, bus.done} !== {exp_busy, exp_pulse, exp_done}) begin
        failures++;
        $display("FAIL inf_model c=%0d got b=%b p=%b d=%b exp b=%b p=%b d=%b",
                 c, bus.busy, bus.pulse_out, bus.done, exp_busy, exp_pulse, exp_done);
      end
      checks++;
      if (bus.done[2] !== 1'b0) begin failures++; $display("FAIL inf_no_done c=%0d got=%b exp=0", c, bus.done[2]); end
      if (bus.pulse_out[2] === 1'b1 && prevp === 1'b0) rises++;
      prevp = bus.pulse_out[2];
      if (rises == 5) begin
        bus.stop[2] = 1'b1;
        found = 1'b1;
      end
      step();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL inf_timeout got_rises=%0d exp=5", rises);
    end
    checks++;
    if (bus.busy[2] !== 1'b0 || bus.pulse_out[2] !== 1'b0 || bus.done[2] !== 1'b0) begin
      failures++;
      $display("FAIL inf_stop got b=%b p=%b d=%b exp 0 0 0", bus.busy[2], bus.pulse_out[2], bus.done[2]);
    end
    bus.stop[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.done[2] !== 1'b0 || bus.busy[2] !== 1'b0) begin
        failures++;
        $display("FAIL inf_after got b=%b d=%b exp 0 0", bus.busy[2], bus.done[2]);
      end
    end
  endtask

  task automatic test_busy_restart();
    int npulse, ndone;
    logic prevp;
    npulse = 0;
    ndone = 0;
    prevp = 1'b0;
    set_cfg(3, 2, 1, 2, 2);
    bus.start[3] = 1'b1;
    step();
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if ({bus.busy, bus.pulse_out, bus.done} !== {exp_busy, exp_pulse, exp_done}) begin
        failures++;
        $display("FAIL restart_model c=%0d got b=%b p=%b d=%b exp b=%b p=%b d=%b",
                 c, bus.busy, bus.pulse_out, bus.done, exp_busy, exp_pulse, exp_done);
      end
      if (bus.pulse_out[3] === 1'b1 && prevp === 1'b0) npulse++;
      if (bus.done[3] === 1'b1) ndone++;
      prevp = bus.pulse_out[3];
      bus.start[3] = (c == 3 || c == 5);
      if (c == 3) set_cfg(3, 0, 5, 0, 7);
      step();
    end
    checks++;
    if (npulse != 2) begin failures++; $display("FAIL restart_pulses got=%0d exp=2", npulse); end
    checks++;
    if (ndone != 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", ndone); end
  endtask

  task automatic test_multi();
    int first_done[NC];
    for (int i = 0; i < NC; i++) begin
      set_cfg(i, 2, i + 1, 1, 2);
      first_done[i] = 0;
    end
    bus.start = '1;
    step();
    for (int c = 1; c <= 14; c++) begin
      bus.start = '0;
      checks++;
      if ({bus.busy, bus.pulse_out, bus.done} !== {exp_busy, exp_pulse, exp_done}) begin
        failures++;
        $display("FAIL multi_model c=%0d got b=%b p=%b d=%b exp b=%b p=%b d=%b",
                 c, bus.busy, bus.pulse_out, bus.done, exp_busy, exp_pulse, exp_done);
      end
      if (c == 2) begin
        checks++;
        if (bus.pulse_out !== 4'h0) begin failures++; $display("FAIL multi_pre_rise got=%b exp=0000", bus.pulse_out); end
      end
      if (c == 3) begin
        checks++;
        if (bus.pulse_out !== 4'hF) begin failures++; $display("FAIL multi_aligned got=%b exp=1111", bus.pulse_out); end
      end
      for (int i = 0; i < NC; i++) begin
        if (bus.done[i] === 1'b1 && first_done[i] == 0) first_done[i] = c;
      end
      step();
    end
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (first_done[i] != 6 + 2 * i) begin
        failures++;
        $display("FAIL multi_done ch=%0d got=%0d exp=%0d", i, first_done[i], 6 + 2 * i);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    set_cfg(0, 2, 5, 1, 0);
    bus.start[0] = 1'b1;
    step();
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.pulse_out[0] === 1'b1) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rmid_timeout got=no_pulse exp=pulse"); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.pulse_out !== '0 || bus.busy !== '0 || bus.done !== '0) begin
      failures++;
      $display("FAIL rmid_immediate got p=%b b=%b d=%b exp all 0", bus.pulse_out, bus.busy, bus.done);
    end
    repeat (3) step();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.busy !== '0 || bus.done !== '0 || {bus.busy, bus.pulse_out, bus.done} !== {exp_busy, exp_pulse, exp_done}) begin
        failures++;
        $display("FAIL rmid_no_restart got b=%b d=%b exp b=%b d=%b", bus.busy, bus.done, exp_busy, exp_done);
      end
    end
    bus.start[0] = 1'b0;
    step();
    bus.start[0] = 1'b1;
    step();
    checks++;
    if (bus.busy[0] !== 1'b1 || bus.busy !== exp_busy) begin
      failures++;
      $display("FAIL rmid_new_edge got=%b exp=%b", bus.busy, exp_busy);
    end
    bus.start[0] = 1'b0;
    bus.stop[0] = 1'b1;
    step();
    bus.stop[0] = 1'b0;
    step();
    checks++;
    if (bus.busy !== '0) begin failures++; $display("FAIL rmid_cleanup got=%b exp=0", bus.busy); end
  endtask

  task automatic test_random();
    set_cfg(0, 1, 1, 1, 1);
    bus.stop[0] = 1'b1;
    bus.start[0] = 1'b1;
    step();
    checks++;
    if (bus.busy[0] !== 1'b0 || bus.busy !== exp_busy) begin
      failures++;
      $display("FAIL stop_beats_start got=%b exp=%b", bus.busy, exp_busy);
    end
    bus.stop[0] = 1'b0;
    bus.start[0] = 1'b0;
    step();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if ({bus.busy, bus.pulse_out, bus.done} !== {exp_busy, exp_pulse, exp_done}) begin
        failures++;
        $display("FAIL random_model c=%0d got b=%b p=%b d=%b exp b=%b p=%b d=%b",
                 c, bus.busy, bus.pulse_out, bus.done, exp_busy, exp_pulse, exp_done);
      end
      for (int ch = 0; ch < NC; ch++) begin
        set_cfg(ch, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        if ($urandom_range(0, 3) == 0) bus.start[ch] = ~bus.start[ch];
        bus.stop[ch] = ($urandom_range(0, 24) == 0);
      end
      step();
    end
    bus.start = '0;
    bus.stop = '1;
    step();
    bus.stop = '0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_min();
    test_back_to_back();
    test_inf_stop();
    test_busy_restart();
    test_multi();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_pulse_generator.md
MULTI_PULSE_GENERATOR -- requirements
Module: multi_pulse_generator

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of delay, gap and width counters.
REQ-003 SHALL have parameter REP_W, default 16, meaning width of the repetition count.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  N_CH  per-channel start request; level, edge-detected internally.
REQ-007 SHALL have port stop  in  N_CH  per-channel synchronous abort.
REQ-008 SHALL have port delay_cycles  in  N_CH*CNT_W  cycles before the first pulse.
REQ-009 SHALL have port gap_cycles  in  N_CH*CNT_W  low cycles between consecutive pulses.
REQ-010 SHALL have port width_cycles  in  N_CH*CNT_W  high cycles per pulse.
REQ-011 SHALL have port repetition  in  N_CH*REP_W  pulse count; 0 = infinite.
REQ-012 SHALL have port pulse_out  out  N_CH  generated pulse, active high.
REQ-013 SHALL have port busy  out  N_CH  channel not IDLE.
REQ-014 SHALL have port done  out  N_CH  one-cycle strobe on natural completion.

Function
REQ-015 SHALL detect start edges as start[i] & ~start_q[i], where start_q is start registered.
REQ-016 SHALL, on a start edge in IDLE, latch that channel's delay, gap, width and repetition into shadow registers; later input changes SHALL NOT affect the run.
REQ-017 SHALL give each channel FSM states IDLE, DELAY, PULSE, GAP.
REQ-018 SHALL transition IDLE->DELAY on start edge, DELAY->PULSE after max(delay,1) cycles, PULSE->GAP or IDLE after max(width,1) cycles, GAP->PULSE after max(gap,1) cycles.
REQ-019 SHALL set latency so that a start edge sampled at edge T puts the channel in DELAY from T+1 and drives pulse_out high from T+1+max(delay,1).
REQ-020 SHALL drive pulse_out high iff state==PULSE, and busy iff state!=IDLE, both registered-state decodes.
REQ-021 SHALL, when repetition=N>0, produce exactly N pulses; after the Nth pulse the channel SHALL go PULSE->IDLE and assert done for exactly the first IDLE cycle.
REQ-022 SHALL, when repetition=0, repeat PULSE/GAP until stop and never assert done.
REQ-023 SHALL ignore a start edge while busy; the edge SHALL NOT be queued.
REQ-024 SHALL, on stop[i] high in any non-IDLE state, enter IDLE next cycle with pulse_out low and no done strobe.
REQ-025 SHALL give stop priority over start in the same cycle, so the channel stays IDLE.
REQ-026 SHALL keep channels fully independent; simultaneous start edges on several channels SHALL yield cycle-aligned outputs when their configurations are equal.
REQ-027 SHALL use saturating-free arithmetic: counters load value-1 (0 treated as 1) and decrement to 0; there SHALL be no wrap-around.
REQ-028 SHALL allow a start edge in the done cycle (IDLE) to begin a new run.

Reset
REQ-029 SHALL, on reset_n low, asynchronously force every channel to IDLE with pulse_out=0, busy=0, done=0, start_q=0, counters=0 and shadow registers=0.
REQ-030 SHALL, when reset is released while start is held high, NOT start a channel until start goes low and high again.
REQ-031 SHALL, on reset mid-run, drop pulse_out within the reset assertion and not strobe done.

Structure
REQ-032 SHALL place the state enum pgen_state_t (2 bits) and default parameter constants in package pulse_gen_pkg.
REQ-033 SHALL implement one channel in sub-module pulse_channel, instantiated N_CH times via generate in multi_pulse_generator.

Verification
REQ-034 SHALL be verified with ch0 delay=3, width=2, gap=4, rep=3 -> pulse_out high at cycles 4-5, 10-11, 16-17 after the start edge, and done at cycle 18.
REQ-035 SHALL be verified with delay=0, width=0, gap=0, rep=2 -> pulses of 1 cycle separated by 1 low cycle, first pulse at T+2.
REQ-036 SHALL be verified with rep=0, stop asserted during the 5th pulse -> IDLE next cycle, pulse_out=0, done never asserted.
REQ-037 SHALL be verified with start re-pulsed while busy and delay_cycles changed mid-run -> run unaffected, no extra pulses.
REQ-038 SHALL be verified with all 4 channels started in the same cycle, differing widths 1/2/3/4 -> aligned rising edges and independent done strobes.
REQ-039 SHALL be verified with reset asserted mid-PULSE while start is held high -> outputs 0 immediately, and no restart after release until a new start edge.
